tt_sweep_controller: RTL and testbench
======================================

Name: tt_sweep_controller

Overview:
- Sequencer that exhaustively exercises one 3-input combinational gate circuit (NOT/NOR netlist, e.g. the 0xEB design).
- Drives all 8 input combinations in order, waits a programmable settle time per vector, and samples the circuit output.
- Assembles the measured truth-table byte and compares it against an expected byte.
- Sits between the circuit-score test harness and the device under test; one controller per circuit instance.

Parameters:
- N_IN, 3, number of circuit inputs; fixed at 3 for this revision, other values unsupported.
- SETTLE_CYCLES, 4, clock cycles each vector is held before the sample cycle; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; honoured only in IDLE.
- abort  input  1  cancel sweep; return to IDLE, no done pulse.
- expected_tt  input  8  golden truth table, MSB-first: expected_tt[7-i] is the output for input index i; latched on accepted start.
- dut_out  input  1  circuit output.
- dut_in  output  3  circuit inputs; index i drives dut_in = i, with dut_in[2]=in2, dut_in[1]=in1, dut_in[0]=in3.
- busy  output  1  high from accepted start until the DONE cycle, inclusive.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  captured_tt == latched expected_tt; valid from done until next accepted start.
- captured_tt  output  8  measured table, same MSB-first ordering.
- mismatch  output  8  captured_tt XOR latched expected_tt.

Behaviour:
- Reset values: state IDLE; dut_in=0, busy=0, done=0, pass=0, captured_tt=0, mismatch=0; internal idx=0, settle count=0, expected latch=0.
- IDLE: on start=1 (and abort=0):
  - latch expected_tt, clear captured_tt/mismatch/pass, idx=0, dut_in=0, cnt=0;
  - go to SETTLE.
- SETTLE: cnt increments each cycle; when cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: captured_tt[7-idx] <= dut_out.
  - If idx==7, go to DONE.
  - Otherwise idx++, dut_in <= idx+1, cnt=0, go to SETTLE.
- DONE: done=1 for exactly this cycle.
  - Registered outputs pass/mismatch take their final values in this cycle, computed from the fully captured table.
  - Next state is IDLE.
- Latency:
  - each vector occupies SETTLE_CYCLES+1 cycles;
  - done asserts 8*(SETTLE_CYCLES+1)+1 rising edges after the edge that accepted start (41 at default).
- dut_in changes only on the SAMPLE->SETTLE transition or on an accepted start, never mid-settle.
- dut_in holds its last value (7) after the sweep completes.
- start while busy: ignored, no restart.
- abort in any non-IDLE state:
  - next state IDLE, busy=0, no done;
  - captured_tt keeps partial contents, pass=0, mismatch=0.
- start and abort together in IDLE: abort wins, start ignored.
- Async reset mid-sweep: all registers go to reset values immediately; no done pulse.
- expected_tt changes during a sweep have no effect, because the value is latched at start.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - localparam TT_W = 2**N_IN (8);
  - localparam IDX_W = N_IN.
- One natural sub-module, tt_settle_timer:
  - loadable down/up counter with clear and terminal-count flag;
  - parameterised by SETTLE_CYCLES.
- FSM, index register and capture/compare logic live in tt_sweep_controller.

Test Plan:
- Golden 0xEB model (out = ~(in3 & (in1 ^ in2))), expected_tt=0xEB, default settle, pulse start -> dut_in steps 0..7 every 5 cycles; done exactly 41 edges after start; captured_tt=0xEB, mismatch=0x00, pass=1.
- Same model, expected_tt=0xEA -> captured_tt=0xEB, mismatch=0x01, pass=0; done timing unchanged.
- SETTLE_CYCLES=1, DUT model with 1-cycle output delay, expected 0xEB -> every vector sampled after settle, captured_tt=0xEB, pass=1; done at edge 17.
- Assert abort after vector 3 is sampled -> busy falls next cycle, no done, pass=0; a subsequent start runs a full clean sweep with pass=1.
- Pulse start again at cycle 10 of an active sweep -> ignored; done still at edge 41 from the original start; change expected_tt mid-sweep -> result still uses the latched value.
- Assert rst asynchronously mid-SETTLE (between edges) -> dut_in, busy and captured_tt go to 0 immediately; after rst deasserts, outputs stay idle until the next start.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and widths for the truth-table sweep controller
package tt_sweep_pkg;
    localparam int N_IN  = 3;
    localparam int TT_W  = 2 ** N_IN;
    localparam int IDX_W = N_IN;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: counts settle cycles and flags the last one
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt;
    // clear has priority so every vector starts its settle window from zero
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= clear ? '0 : en ? cnt + CNT_W'(1) : cnt;
    assign tc = cnt == CNT_W'(SETTLE_CYCLES - 1);
endmodule

// File: rtl/tt_sweep_controller.sv
// tt_sweep_controller: walks all input vectors of a 3-input gate and checks its truth table
module tt_sweep_controller
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [TT_W-1:0]  expected_tt,
    input  logic             dut_out,
    output logic [IDX_W-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TT_W-1:0]  captured_tt,
    output logic [TT_W-1:0]  mismatch
);
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TT_W-1:0]  exp_q;
    logic             tc;

    tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state != SETTLE),
        .en   (state == SETTLE),
        .tc   (tc)
    );

    // the index register is the vector driven to the circuit, so dut_in only moves when idx does
    assign dut_in = idx;

    // sweep sequencer: capture one bit per vector, then publish the comparison in DONE
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            exp_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            captured_tt <= '0;
            mismatch    <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                busy     <= 1'b0;
                pass     <= 1'b0;
                mismatch <= '0;
            end else
                case (state)
                    IDLE:
                        if (start && !abort) begin
                            exp_q       <= expected_tt;
                            captured_tt <= '0;
                            mismatch    <= '0;
                            pass        <= 1'b0;
                            idx         <= '0;
                            busy        <= 1'b1;
                            state       <= SETTLE;
                        end
                    SETTLE:
                        if (tc) state <= SAMPLE;
                    SAMPLE: begin
                        // ~idx is 7-idx: the table is stored MSB-first
                        captured_tt[~idx] <= dut_out;
                        if (idx == IDX_W'(TT_W - 1)) state <= DONE;
                        else begin
                            idx   <= idx + IDX_W'(1);
                            state <= SETTLE;
                        end
                    end
                    DONE: begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        pass     <= captured_tt == exp_q;
                        mismatch <= captured_tt ^ exp_q;
                        state    <= IDLE;
                    end
                endcase
        end
endmodule

// File: tb/tb_tt_sweep_controller.sv
// tb_tt_sweep_controller: directed vector table plus corner-case sequences for the sweep controller
module tb_tt_sweep_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0;
    logic [7:0] expected_tt = 8'h00;
    logic       dut_out;
    logic [2:0] dut_in;
    logic       busy, done, pass;
    logic [7:0] captured_tt, mismatch;

    logic       start_f = 1'b0, abort_f = 1'b0;
    logic [7:0] expected_f = 8'hEB;
    logic       out_f = 1'b1;
    logic [2:0] in_f;
    logic       busy_f, done_f, pass_f;
    logic [7:0] captured_f, mismatch_f;

    int nvec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    function automatic logic gate(input logic [2:0] v);
        return ~(v[0] & (v[1] ^ v[2]));
    endfunction

    assign dut_out = gate(dut_in);
    always @(posedge clk) out_f <= gate(in_f);

    tt_sweep_controller u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_tt(expected_tt),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
        .captured_tt(captured_tt), .mismatch(mismatch)
    );

    tt_sweep_controller #(.SETTLE_CYCLES(1)) u_fast (
        .clk(clk), .rst(rst), .start(start_f), .abort(abort_f), .expected_tt(expected_f),
        .dut_out(out_f), .dut_in(in_f), .busy(busy_f), .done(done_f), .pass(pass_f),
        .captured_tt(captured_f), .mismatch(mismatch_f)
    );

    typedef struct {
        logic [7:0] exp_tt;
        logic [7:0] cap;
        logic [7:0] mis;
        logic       ok;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // runs a default-settle sweep; optionally re-pulses start and changes expected_tt at edge 10
    task automatic run_sweep(input logic [7:0] tt, input logic poke, output int n);
        logic [2:0] want_in;
        int bad = 0;
        expected_tt = tt;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (poke && k == 9) begin start = 1'b1; expected_tt = ~tt; end
            if (poke && k == 10) start = 1'b0;
            want_in = (k / 5 > 7) ? 3'd7 : 3'(k / 5);
            if (dut_in !== want_in) bad++;
            if (busy !== (k < 41)) bad++;
            if (done) begin n = k; break; end
        end
        start = 1'b0;
        chk("dut_in_busy_seq", bad, 0);
        chk("done_edge", n, 41);
        step();
        chk("done_one_cycle", {31'd0, done}, 0);
    endtask

    initial begin
        int n;
        int seen;
        vecs[0] = '{8'hEB, 8'hEB, 8'h00, 1'b1};
        vecs[1] = '{8'hEA, 8'hEB, 8'h01, 1'b0};
        vecs[2] = '{8'h00, 8'hEB, 8'hEB, 1'b0};
        vecs[3] = '{8'hFF, 8'hEB, 8'h14, 1'b0};

        step();
        step();
        chk("reset_outputs", {dut_in, busy, done, pass, captured_tt, mismatch}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            run_sweep(vecs[i].exp_tt, 1'b0, n);
            chk("captured_tt", captured_tt, vecs[i].cap);
            chk("mismatch", mismatch, vecs[i].mis);
            chk("pass", pass, vecs[i].ok);
        end

        // short settle with a one-cycle-late circuit model
        start_f = 1'b1;
        step();
        start_f = 1'b0;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done_f) begin n = k; break; end
        end
        chk("fast_done_edge", n, 17);
        chk("fast_captured", captured_f, 8'hEB);
        chk("fast_pass", pass_f, 1);

        // abort right after vector 3 is sampled at edge 20
        expected_tt = 8'hEB;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_pass_mis", {busy, pass, mismatch}, 0);
        chk("abort_partial", captured_tt, 8'hE0);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_sweep(8'hEB, 1'b0, n);
        chk("after_abort_pass", pass, 1);

        // start re-pulsed and expected_tt changed mid-sweep
        run_sweep(8'hEB, 1'b1, n);
        chk("latched_pass", {pass, mismatch}, {1'b1, 8'h00});

        // abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", busy, 0);

        // asynchronous reset mid-settle
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("pre_reset_partial", captured_tt, 8'hC0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {dut_in, busy, captured_tt}, 0);
        #2 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done || busy || dut_in != 3'd0) seen++;
        end
        chk("idle_after_reset", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
